// File: rtl/centroid_marker_overlay.sv
// centroid_marker_overlay
//   Draws crosshair markers at up to four player centroids over a streamed
//   pixel coordinate. Incoming centroids are held in a pending buffer and
//   become visible only at a frame boundary, so a marker never tears
//   mid-frame. Markers are hidden once STALE_FRAMES frames pass without a
//   committed update.
// Ports:
//   clk_in, rst_in            clock, asynchronous active-high reset
//   centroid_x_in/_y_in       per-player centroid (4 entries)
//   centroid_valid_in         one-cycle strobe, centroids valid
//   num_players_in            enabled players minus one (latched per frame)
//   new_frame_in              frame-start pulse, coincident with pixel (0,0)
//   hcount_in/vcount_in       pixel coordinate, qualified by pixel_valid_in
//   marker_out/player_out     pixel hit and owning player (2-cycle latency)
//   valid_out                 pixel_valid_in delayed by 2 cycles
//   active_out                markers currently visible
module centroid_marker_overlay #(
  parameter int unsigned MARKER_HALF  = 8,
  parameter int unsigned MARKER_THICK = 1,
  parameter int unsigned STALE_FRAMES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [3:0][10:0] centroid_x_in,
  input  logic [3:0][9:0]  centroid_y_in,
  input  logic             centroid_valid_in,
  input  logic [1:0]       num_players_in,
  input  logic             new_frame_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             pixel_valid_in,
  output logic             marker_out,
  output logic [1:0]       player_out,
  output logic             valid_out,
  output logic             active_out
);

  localparam logic [3:0]  STALE_MAX = 4'(STALE_FRAMES);
  localparam logic [11:0] HALF      = 12'(MARKER_HALF);
  localparam logic [11:0] THICK     = 12'(MARKER_THICK);

  logic [3:0][10:0] pend_x, act_x;
  logic [3:0][9:0]  pend_y, act_y;
  logic             pending_flag;
  logic             ever_committed;
  logic [3:0]       stale_count;
  logic [1:0]       active_num;

  logic [10:0]      s1_h;
  logic [9:0]       s1_v;
  logic             s1_valid;

  logic             commit;
  logic [3:0]       stale_next;
  logic             ever_next;
  logic [3:0]       hit;
  logic [1:0]       first_hit;
  logic             draw;

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign commit = new_frame_in && (pending_flag || centroid_valid_in);

  always_comb begin
    stale_next = stale_count;
    ever_next  = ever_committed;
    if (commit) begin
      stale_next = '0;
      ever_next  = 1'b1;
    end else if (new_frame_in && (stale_count < STALE_MAX)) begin
      stale_next = stale_count + 4'd1;
    end
  end

  // Centroid capture / commit. active_out is registered from the next-state
  // values so it changes on the same edge as the commit or increment.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_x         <= '0;
      pend_y         <= '0;
      act_x          <= '0;
      act_y          <= '0;
      pending_flag   <= 1'b0;
      ever_committed <= 1'b0;
      stale_count    <= STALE_MAX;
      active_num     <= '0;
      active_out     <= 1'b0;
    end else begin
      if (centroid_valid_in) begin
        pend_x       <= centroid_x_in;
        pend_y       <= centroid_y_in;
        pending_flag <= 1'b1;
      end
      if (new_frame_in) begin
        active_num <= num_players_in;
      end
      if (commit) begin
        pending_flag <= 1'b0;
        act_x        <= centroid_valid_in ? centroid_x_in : pend_x;
        act_y        <= centroid_valid_in ? centroid_y_in : pend_y;
      end
      stale_count    <= stale_next;
      ever_committed <= ever_next;
      active_out     <= ever_next && (stale_next < STALE_MAX);
    end
  end

  // Stage 1 register; hit test runs on the registered coordinate so a pixel
  // arriving with new_frame_in is compared against the freshly committed set.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_h     <= '0;
      s1_v     <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_h     <= hcount_in;
      s1_v     <= vcount_in;
      s1_valid <= pixel_valid_in;
    end
  end

  always_comb begin
    hit = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      logic [11:0] dx;
      logic [11:0] dy;
      dx = abs_diff({1'b0, s1_h}, {1'b0, act_x[p]});
      dy = abs_diff({2'b00, s1_v}, {2'b00, act_y[p]});
      if (2'(p) <= active_num) begin
        hit[p] = ((dx <= HALF) && (dy <= THICK)) || ((dy <= HALF) && (dx <= THICK));
      end
    end
  end

  // Lowest index wins: scan from 3 down so player 0 overwrites last.
  always_comb begin
    first_hit = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (hit[3 - k]) begin
        first_hit = 2'(3 - k);
      end
    end
  end

  assign draw = s1_valid && active_out && (|hit);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      marker_out <= 1'b0;
      player_out <= '0;
      valid_out  <= 1'b0;
    end else begin
      marker_out <= draw;
      player_out <= draw ? first_hit : '0;
      valid_out  <= s1_valid;
    end
  end

endmodule

// File: tb/tb_centroid_marker_overlay.sv
module tb_centroid_marker_overlay;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [3:0][10:0] centroid_x_in;
  logic [3:0][9:0]  centroid_y_in;
  logic             centroid_valid_in;
  logic [1:0]       num_players_in;
  logic             new_frame_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             pixel_valid_in;
  logic             marker_out;
  logic [1:0]       player_out;
  logic             valid_out;
  logic             active_out;

  always #5 clk_in = ~clk_in;

  centroid_marker_overlay #(
    .MARKER_HALF (8),
    .MARKER_THICK(1),
    .STALE_FRAMES(4)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .centroid_x_in    (centroid_x_in),
    .centroid_y_in    (centroid_y_in),
    .centroid_valid_in(centroid_valid_in),
    .num_players_in   (num_players_in),
    .new_frame_in     (new_frame_in),
    .hcount_in        (hcount_in),
    .vcount_in        (vcount_in),
    .pixel_valid_in   (pixel_valid_in),
    .marker_out       (marker_out),
    .player_out       (player_out),
    .valid_out        (valid_out),
    .active_out       (active_out)
  );

  typedef struct {
    logic       m;
    logic [1:0] p;
    int         id;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // One clock of stimulus; expected pixel response goes to the scoreboard.
  task automatic cyc(input logic strobe, input logic nf, input logic pv,
                     input int h, input int v, input logic em,
                     input logic [1:0] ep, input int id);
    centroid_valid_in = strobe;
    new_frame_in      = nf;
    pixel_valid_in    = pv;
    hcount_in         = 11'(h);
    vcount_in         = 10'(v);
    if (pv) sbq.push_back('{em, ep, id});
    @(posedge clk_in);
    #1;
    centroid_valid_in = 1'b0;
    new_frame_in      = 1'b0;
    pixel_valid_in    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 2'd0, 0);
  endtask

  task automatic pix(input int h, input int v, input logic em,
                     input logic [1:0] ep, input int id);
    cyc(1'b0, 1'b0, 1'b1, h, v, em, ep, id);
  endtask

  task automatic set_c(input int p, input int x, input int y);
    centroid_x_in[p] = 11'(x);
    centroid_y_in[p] = 10'(y);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pixel.
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (valid_out) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid marker=%0d player=%0d expected=no_output",
                   marker_out, player_out);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (marker_out !== e.m || player_out !== e.p) begin
            failures++;
            $display("FAIL pixel_%0d marker=%0d player=%0d expected marker=%0d player=%0d",
                     e.id, marker_out, player_out, e.m, e.p);
          end
        end
      end else if (marker_out !== 1'b0 || player_out !== 2'd0) begin
        checks++;
        failures++;
        $display("FAIL idle_outputs marker=%0d player=%0d expected 0/0",
                 marker_out, player_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in            = 1'b1;
    centroid_x_in     = '0;
    centroid_y_in     = '0;
    centroid_valid_in = 1'b0;
    num_players_in    = 2'd0;
    new_frame_in      = 1'b0;
    hcount_in         = '0;
    vcount_in         = '0;
    pixel_valid_in    = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_marker", int'(marker_out), 0);
    chk("reset_player", int'(player_out), 0);
    chk("reset_valid",  int'(valid_out),  0);
    chk("reset_active", int'(active_out), 0);
    rst_in = 1'b0;
    idle(1);

    // Single player at (100,50)
    num_players_in = 2'd0;
    set_c(0, 100, 50);
    set_c(1, 1000, 700);
    set_c(2, 1000, 700);
    set_c(3, 1000, 700);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    chk("active_before_commit", int'(active_out), 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    chk("active_after_commit", int'(active_out), 1);
    pix(100, 50, 1'b1, 2'd0, 1);
    pix(108, 50, 1'b1, 2'd0, 2);
    pix(108, 51, 1'b1, 2'd0, 3);
    pix(109, 50, 1'b0, 2'd0, 4);
    pix(108, 52, 1'b0, 2'd0, 5);
    pix(100, 42, 1'b1, 2'd0, 6);
    pix(101, 41, 1'b0, 2'd0, 7);
    idle(3);

    // Overlap priority
    num_players_in = 2'd1;
    set_c(0, 200, 100);
    set_c(1, 205, 100);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    pix(203, 100, 1'b1, 2'd0, 10);
    pix(212, 100, 1'b1, 2'd1, 11);
    pix(214, 100, 1'b0, 2'd0, 12);
    idle(3);

    // Disabled player 1
    num_players_in = 2'd0;
    set_c(0, 100, 50);
    set_c(1, 300, 300);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    pix(300, 300, 1'b0, 2'd0, 20);
    pix(100, 50, 1'b1, 2'd0, 21);
    idle(3);

    // Deferred commit, then same-cycle bypass
    set_c(0, 400, 200);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    pix(400, 200, 1'b0, 2'd0, 30);
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    pix(400, 200, 1'b1, 2'd0, 31);
    set_c(0, 50, 60);
    cyc(1'b1, 1'b1, 1'b1, 50, 60, 1'b1, 2'd0, 32);
    idle(3);

    // Staleness: four frames without an update hide the markers
    for (int f = 1; f <= 3; f++) begin
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
      chk("active_stale_frame", int'(active_out), 1);
    end
    cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    chk("active_stale_4", int'(active_out), 0);
    pix(50, 60, 1'b0, 2'd0, 40);
    idle(3);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    chk("active_recovered", int'(active_out), 1);
    pix(50, 60, 1'b1, 2'd0, 41);
    idle(3);

    // Screen-edge clipping, no wrap-around
    set_c(0, 3, 2);
    cyc(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'd0, 0);
    pix(0, 2, 1'b1, 2'd0, 50);
    pix(2047, 2, 1'b0, 2'd0, 51);
    pix(0, 0, 1'b0, 2'd0, 52);
    pix(3, 1023, 1'b0, 2'd0, 53);
    idle(3);

    // Asynchronous reset while a hit is on the outputs
    set_c(0, 100, 50);
    cyc(1'b1, 1'b1, 1'b1, 100, 50, 1'b1, 2'd0, 60);
    idle(1);
    chk("pre_reset_valid",  int'(valid_out),  1);
    chk("pre_reset_marker", int'(marker_out), 1);
    #2;
    rst_in = 1'b1;
    sbq.delete();
    #1;
    chk("async_reset_marker", int'(marker_out), 0);
    chk("async_reset_valid",  int'(valid_out),  0);
    chk("async_reset_active", int'(active_out), 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(1);
    chk("post_reset_valid",  int'(valid_out),  0);
    chk("post_reset_active", int'(active_out), 0);
    pix(100, 50, 1'b0, 2'd0, 61);
    cyc(1'b1, 1'b1, 1'b1, 100, 50, 1'b1, 2'd0, 62);
    idle(3);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sbq.size() != 0; i++) idle(1);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/centroid_marker_overlay.md
Name: centroid_marker_overlay

Overview:
- Consumer end of the player-tracking path: takes per-frame centroid results (4 x/y pairs plus an update strobe) and draws a crosshair marker at each enabled player's centroid.
- Holds incoming centroids in a pending buffer and commits them only at a frame boundary, so markers never tear mid-frame.
- Classifies a streamed pixel coordinate as marker/non-marker with the owning player index, 2-cycle latency.
- Sits between the clustering stage and the video compositor; also blanks markers when updates go stale.

Parameters:
MARKER_HALF, 8, crosshair arm half-length in pixels.
MARKER_THICK, 1, crosshair arm half-thickness in pixels.
STALE_FRAMES, 4, frames without a committed update before markers are hidden (1..15).

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-high
centroid_x_in  input  11 x [3:0]  centroid x per player
centroid_y_in  input  10 x [3:0]  centroid y per player
centroid_valid_in  input  1  one-cycle strobe: centroid_x_in/centroid_y_in valid
num_players_in  input  2  enabled players minus one
new_frame_in  input  1  one-cycle pulse, coincident with pixel (0,0)
hcount_in  input  11  pixel x
vcount_in  input  10  pixel y
pixel_valid_in  input  1  hcount_in/vcount_in valid
marker_out  output  1  pixel lies on a visible marker
player_out  output  2  owning player index (0 when marker_out=0)
valid_out  output  1  pixel_valid_in delayed 2 cycles
active_out  output  1  markers currently visible

Behaviour:
- Clock clk_in; reset rst_in is asynchronous, active-high. On reset: marker_out, player_out, valid_out, active_out = 0; pending and active centroid registers = 0; pending_flag = 0; ever_committed = 0; stale_count = STALE_FRAMES; pipeline valids cleared. Reset mid-frame flushes in-flight pixels; no output valid until new pixels enter after release.
- Capture: centroid_valid_in=1 -> all four pending x/y registers load; pending_flag <= 1. A later strobe before commit overwrites pending (last wins).
- Commit, on new_frame_in=1:
  - If pending_flag or centroid_valid_in: active centroids <= pending, or the incoming values directly if centroid_valid_in is high that cycle (bypass). pending_flag <= 0, stale_count <= 0, ever_committed <= 1.
  - Otherwise stale_count <= min(stale_count+1, STALE_FRAMES).
  - num_players_in is latched into active_num on every new_frame_in. It is never sampled elsewhere.
- active_out = ever_committed && (stale_count < STALE_FRAMES). This is a registered value that updates the cycle after the commit or increment.
- Pixel pipeline, fixed 2-cycle latency:
  - Stage 1 registers hcount/vcount/pixel_valid. A pixel presented with new_frame_in therefore sees the newly committed set.
  - Stage 1 compute, for each player p <= active_num: dx = |h - cx_p| and dy = |v - cy_p|. Use 12-bit unsigned absolute difference with no wrap.
  - hit_p = (dx <= MARKER_HALF && dy <= MARKER_THICK) || (dy <= MARKER_HALF && dx <= MARKER_THICK). Players above active_num never hit.
  - Stage 2 registers marker_out = any hit_p && active_out && valid, and player_out = lowest-index hitting player (fixed priority 0>1>2>3), else 0.
  - valid_out = stage-1 valid registered. marker_out and player_out are 0 whenever valid_out=0.
- Markers near screen edges are clipped naturally; coordinates never wrap.
- Back-to-back pixels every cycle are supported; no stall or backpressure.

Test Plan:
- Reset asserted asynchronously mid-stream -> marker_out, valid_out, active_out go 0 immediately. They stay 0 until a commit and pixels 2 cycles post-release.
- Single player: num_players_in=0, centroid 0=(100,50), strobe then new_frame_in.
  - (100,50) -> marker_out=1, player_out=0 exactly 2 cycles later.
  - (108,50) and (108,51) -> hit.
  - (109,50) and (108,52) -> miss.
- Overlap priority: num_players_in=1, centroids (200,100) and (205,100); pixel (203,100) -> marker_out=1, player_out=0. Pixel (212,100) -> player_out=1.
- Disabled player: num_players_in=0, centroid 1=(300,300); pixel (300,300) -> marker_out=0.
- Deferred commit and bypass:
  - Strobe (400,200) without new_frame_in -> pixel (400,200) still misses.
  - After new_frame_in -> hit.
  - Strobe and new_frame_in in the same cycle with (50,60) -> pixel (50,60) presented in that cycle hits.
- Staleness, STALE_FRAMES=4:
  - After a commit, 4 new_frame_in pulses with no strobe -> active_out falls to 0 after the 4th and markers disappear.
  - Next strobe plus new_frame_in -> active_out returns to 1.
